i2s_rx_framed: RTL and testbench

I2S_RX_FRAMED -- requirements
Module: i2s_rx_framed

---
 rtl/i2s_rx_framed.sv | 149 ++++++++++++++
 tb/tb_i2s_rx_framed.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_framed.sv
// I2S / left-justified stereo receiver. Deserialises left and right slots and presents
// them as a pair through a valid/ready buffer, with sticky overrun and slot-length flags.
module i2s_rx_framed #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 32,
  parameter int OFFSET_BIN = 0
) (
  input  logic                  sclk_i,
  input  logic                  rst_i,
  input  logic                  ws_i,
  input  logic                  sdata_i,
  input  logic                  mode_i,
  input  logic                  ready_i,
  input  logic                  err_clr_i,
  output logic [DATA_WIDTH-1:0] left_o,
  output logic [DATA_WIDTH-1:0] right_o,
  output logic                  valid_o,
  output logic                  overrun_o,
  output logic                  slot_err_o
);

  localparam int CW = $clog2(SLOT_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] SLOT_LEN = CW'(SLOT_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MSB_FLIP =
    (OFFSET_BIN != 0) ? (DATA_WIDTH'(1) << (DATA_WIDTH - 1)) : '0;

  // SEED: next edge only loads history; HUNT: waiting for the first slot start;
  // RUN: inside a slot whose start was seen, so it may be finalised.
  typedef enum logic [1:0] {
    ST_SEED = 2'd0,
    ST_HUNT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                state;
  logic                  ws_q;
  logic                  mode_q;
  logic                  w_prev;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] cap;
  logic [DATA_WIDTH-1:0] pend;
  logic                  pend_vld;
  logic [DATA_WIDTH-1:0] sample;

  logic w;
  logic resync;
  logic slot_start;
  logic finalise;
  logic frame;
  logic accept;
  logic slot_short;

  assign w          = mode_i ? ws_i : ws_q;
  assign resync     = (mode_i != mode_q);
  assign slot_start = (state != ST_SEED) && !resync && (w != w_prev);
  assign finalise   = slot_start && (state == ST_RUN);
  assign slot_short = (count != SLOT_LEN);
  // The slot being finalised belongs to the previous select value (1 = right).
  assign frame      = finalise && w_prev && pend_vld;
  assign accept     = valid_o && ready_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    sample = cap;
    if (int'(count) < DATA_WIDTH) begin
      sample = cap << (DATA_WIDTH - int'(count));
    end
    sample = sample ^ MSB_FLIP;
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge sclk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_SEED;
      ws_q       <= 1'b0;
      mode_q     <= 1'b0;
      w_prev     <= 1'b0;
      count      <= '0;
      cap        <= '0;
      pend       <= '0;
      pend_vld   <= 1'b0;
      left_o     <= '0;
      right_o    <= '0;
      valid_o    <= 1'b0;
      overrun_o  <= 1'b0;
      slot_err_o <= 1'b0;
    end else begin
      ws_q   <= ws_i;
      mode_q <= mode_i;

      if (state == ST_SEED || resync) begin
        // After reset ws_q is still stale, so history is seeded from ws_i; this keeps
        // the reset value of ws_q from faking a slot start in I2S mode.
        w_prev   <= (state == ST_SEED) ? ws_i : w;
        state    <= ST_HUNT;
        count    <= '0;
        cap      <= '0;
        pend     <= '0;
        pend_vld <= 1'b0;
      end else begin
        w_prev <= w;
        if (slot_start) begin
          state <= ST_RUN;
          count <= CW'(1);
          cap   <= DATA_WIDTH'(sdata_i);
        end else if (state == ST_RUN) begin
          if (count != CNT_MAX) begin
            count <= count + 1'b1;
          end
          if (int'(count) < DATA_WIDTH) begin
            cap <= (cap << 1) | DATA_WIDTH'(sdata_i);
          end
        end

        if (finalise && !w_prev) begin
          pend     <= sample;
          pend_vld <= 1'b1;
        end
        if (frame) begin
          pend     <= '0;
          pend_vld <= 1'b0;
        end
      end

      if (err_clr_i) begin
        overrun_o  <= 1'b0;
        slot_err_o <= 1'b0;
      end
      if (finalise && slot_short) begin
        slot_err_o <= 1'b1;
      end

      if (frame) begin
        if (!valid_o || ready_i) begin
          left_o  <= pend;
          right_o <= sample;
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (accept) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_framed.sv
// Directed bench for i2s_rx_framed: bit streams are built per test and played one bit
// per sclk; outputs are sampled 1 time unit after the rising edge.
module tb_i2s_rx_framed;

  logic        sclk_i;
  logic        rst_i;
  logic        ws_i;
  logic        sdata_i;
  logic        mode_i;
  logic        ready_i;
  logic        err_clr_i;
  logic [15:0] left_o, right_o;
  logic        valid_o, overrun_o, slot_err_o;
  logic [15:0] left_ob, right_ob;
  logic        valid_ob, overrun_ob, slot_err_ob;

  int n_checks = 0;
  int n_pass   = 0;

  logic ws_a[$];
  logic sd_a[$];

  int          fv;
  logic [15:0] fl, fr, fl_ob, fr_ob;
  logic [15:0] sl, sr;
  logic        sv, so;

  i2s_rx_framed #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .OFFSET_BIN(0)) dut (
    .sclk_i(sclk_i), .rst_i(rst_i), .ws_i(ws_i), .sdata_i(sdata_i), .mode_i(mode_i),
    .ready_i(ready_i), .err_clr_i(err_clr_i), .left_o(left_o), .right_o(right_o),
    .valid_o(valid_o), .overrun_o(overrun_o), .slot_err_o(slot_err_o)
  );

  i2s_rx_framed #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .OFFSET_BIN(1)) dut_ob (
    .sclk_i(sclk_i), .rst_i(rst_i), .ws_i(ws_i), .sdata_i(sdata_i), .mode_i(mode_i),
    .ready_i(ready_i), .err_clr_i(err_clr_i), .left_o(left_ob), .right_o(right_ob),
    .valid_o(valid_ob), .overrun_o(overrun_ob), .slot_err_o(slot_err_ob)
  );

  initial sclk_i = 1'b0;
  always #5 sclk_i = ~sclk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic add_slot(input logic ws, input logic [31:0] word, input int wbits,
                          input int slen);
    logic [31:0] t;
    for (int i = 0; i < slen; i++) begin
      t = (i < wbits) ? (word >> (wbits - 1 - i)) : 32'd0;
      ws_a.push_back(ws);
      sd_a.push_back(t[0]);
    end
  endtask

  // Stream is built left-justified; early=1 moves ws one bit ahead for I2S framing.
  task automatic play(input logic mode_base, input bit early, input int rdy_from,
                      input int clr_at, input int mflip_at, input int snap_at);
    int n;
    n  = ws_a.size();
    fv = -1;
    for (int j = 0; j < n; j++) begin
      @(negedge sclk_i);
      rst_i     = 1'b1;
      ws_i      = (early && (j + 1 < n)) ? ws_a[j+1] : ws_a[j];
      sdata_i   = sd_a[j];
      ready_i   = (j >= rdy_from);
      err_clr_i = (j == clr_at);
      mode_i    = (j == mflip_at) ? ~mode_base : mode_base;
      @(posedge sclk_i);
      #1;
      if (valid_o && fv < 0) begin
        fv = j; fl = left_o; fr = right_o; fl_ob = left_ob; fr_ob = right_ob;
      end
      if (j == snap_at) begin
        sl = left_o; sr = right_o; sv = valid_o; so = overrun_o;
      end
    end
    err_clr_i = 1'b0;
    ws_a.delete();
    sd_a.delete();
  endtask

  task automatic apply_reset();
    @(negedge sclk_i);
    rst_i     = 1'b0;
    err_clr_i = 1'b0;
    repeat (2) @(negedge sclk_i);
  endtask

  task automatic clear_flags();
    @(negedge sclk_i);
    err_clr_i = 1'b1;
    @(posedge sclk_i);
    #1;
    err_clr_i = 1'b0;
  endtask

  task automatic std_stream(input logic [15:0] l, input logic [15:0] r);
    add_slot(1'b1, 32'h0, 0, 4);
    add_slot(1'b0, {16'h0, l}, 16, 32);
    add_slot(1'b1, {16'h0, r}, 16, 32);
  endtask

  initial begin
    rst_i = 1'b1; ws_i = 1'b0; sdata_i = 1'b0; mode_i = 1'b0;
    ready_i = 1'b1; err_clr_i = 1'b0;
    #1 rst_i = 1'b0;
    #2;
    check("rst_left",  left_o,     0);
    check("rst_right", right_o,    0);
    check("rst_valid", valid_o,    0);
    check("rst_ovr",   overrun_o,  0);
    check("rst_serr",  slot_err_o, 0);
    apply_reset();

    // I2S, 32-bit slots
    std_stream(16'h1234, 16'hABCD);
    add_slot(1'b0, 32'h0, 0, 2);
    play(1'b0, 1'b1, 0, -1, -1, -1);
    check("i2s_idx",   fv, 68);
    check("i2s_left",  fl, 16'h1234);
    check("i2s_right", fr, 16'hABCD);
    check("i2s_serr",  slot_err_o, 0);
    check("i2s_ovr",   overrun_o, 0);

    // left-justified, ws aligned with MSB
    apply_reset();
    std_stream(16'h1234, 16'hABCD);
    add_slot(1'b0, 32'h0, 0, 2);
    play(1'b1, 1'b0, 0, -1, -1, -1);
    check("lj_idx",   fv, 68);
    check("lj_left",  fl, 16'h1234);
    check("lj_right", fr, 16'hABCD);

    // same LJ-aligned stream decoded as I2S: one-bit shift
    apply_reset();
    std_stream(16'h1234, 16'hABCD);
    add_slot(1'b0, 32'h0, 0, 2);
    play(1'b0, 1'b0, 0, -1, -1, -1);
    check("shift_idx",   fv, 69);
    check("shift_left",  fl, 16'h2468);
    check("shift_right", fr, 16'h579A);
    check("shift_serr",  slot_err_o, 0);

    // 12-bit slots, offset-binary instance inverts the MSB
    apply_reset();
    add_slot(1'b1, 32'h0, 0, 4);
    add_slot(1'b0, 32'h800, 12, 12);
    add_slot(1'b1, 32'hFFF, 12, 12);
    add_slot(1'b0, 32'h0, 0, 2);
    play(1'b1, 1'b0, 0, -1, -1, -1);
    check("ob_idx",       fv, 28);
    check("ob_left",      fl_ob, 16'h0000);
    check("ob_right",     fr_ob, 16'h7FF0);
    check("ob_serr",      slot_err_ob, 1);
    check("short_left",   fl, 16'h8000);
    check("short_right",  fr, 16'hFFF0);
    check("short_serr",   slot_err_o, 1);
    clear_flags();
    check("clr_serr",    slot_err_o, 0);
    check("clr_serr_ob", slot_err_ob, 0);

    // two frames with ready low: first held, second dropped; clear on drop edge loses
    apply_reset();
    std_stream(16'h1111, 16'h2222);
    add_slot(1'b0, 32'h3333, 16, 32);
    add_slot(1'b1, 32'h4444, 16, 32);
    add_slot(1'b0, 32'h0, 0, 2);
    play(1'b1, 1'b0, 1000, 132, -1, 133);
    check("hold_idx",   fv, 68);
    check("hold_left",  sl, 16'h1111);
    check("hold_right", sr, 16'h2222);
    check("hold_valid", sv, 1);
    check("hold_ovr",   so, 1);
    clear_flags();
    check("clr_ovr",       overrun_o, 0);
    check("clr_keepvalid", valid_o, 1);
    #2 rst_i = 1'b0;
    #1;
    check("async_left",  left_o, 0);
    check("async_right", right_o, 0);
    check("async_valid", valid_o, 0);
    apply_reset();

    // ready rises on the edge the second frame loads
    std_stream(16'h1111, 16'h2222);
    add_slot(1'b0, 32'h3333, 16, 32);
    add_slot(1'b1, 32'h4444, 16, 32);
    add_slot(1'b0, 32'h0, 0, 2);
    play(1'b1, 1'b0, 132, -1, -1, 132);
    check("swap_left",  sl, 16'h3333);
    check("swap_right", sr, 16'h4444);
    check("swap_valid", sv, 1);
    check("swap_ovr",   so, 0);
    check("swap_drain", valid_o, 0);

    // reset released mid-right-slot, I2S
    apply_reset();
    add_slot(1'b1, 32'h2AB, 10, 10);
    add_slot(1'b0, 32'h5A5A, 16, 32);
    add_slot(1'b1, 32'hA5A5, 16, 32);
    add_slot(1'b0, 32'h0, 0, 2);
    play(1'b0, 1'b1, 0, -1, -1, -1);
    check("mid_idx",   fv, 74);
    check("mid_left",  fl, 16'h5A5A);
    check("mid_right", fr, 16'hA5A5);
    check("mid_serr",  slot_err_o, 0);

    // mode toggle inside the first left slot discards that frame
    apply_reset();
    std_stream(16'h1111, 16'h2222);
    add_slot(1'b0, 32'h3333, 16, 32);
    add_slot(1'b1, 32'h4444, 16, 32);
    add_slot(1'b0, 32'h0, 0, 2);
    play(1'b1, 1'b0, 0, -1, 10, -1);
    check("resync_idx",   fv, 132);
    check("resync_left",  fl, 16'h3333);
    check("resync_right", fr, 16'h4444);
    check("resync_serr",  slot_err_o, 0);
    check("resync_ovr",   overrun_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
